// File: rtl/capture_pkg.sv
// capture_pkg: state type, widths and default run length shared by the capture sink files.
package capture_pkg;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W = 32;
  localparam int CNT_W = 15;
  localparam int MAX_SAMPLES_DEF = 16384;
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} cap_state_t;
endpackage

// File: rtl/capture_seq_check.sv
// capture_seq_check: sticky flag for accepted samples that break the +1 ramp (0xFFFF->0x0000 wrap is legal).
module capture_seq_check
  import capture_pkg::*;
(
  input  logic                dclk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                first,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] data,
  output logic                seq_err
);
  logic [SAMPLE_W-1:0] expected;
  always_ff @(posedge dclk or negedge rst_n)
    if (!rst_n) begin
      expected <= '0;
      seq_err <= 1'b0;
    end else if (clear) begin
      expected <= '0;
      seq_err <= 1'b0;
    end else if (valid) begin
      expected <= data + 1'b1;
      if (!first && data != expected) seq_err <= 1'b1;
    end
endmodule

// File: rtl/capture_sink.sv
// capture_sink: packs 16-bit sample pairs into 32-bit FIFO words, with completion and overflow status.
// Optional sequence checker compiled in with CAPTURE_SEQ_CHECK_EN.
module capture_sink
  import capture_pkg::*;
#(
  parameter int MAX_SAMPLES = MAX_SAMPLES_DEF
) (
  input  logic                dclk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                dv,
  input  logic [SAMPLE_W-1:0] data,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [WORD_W-1:0]   fifo_din,
  output logic                capture_done,
  output logic [CNT_W-1:0]    sample_count,
  output logic                overflow,
  output logic                seq_err
);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);
  cap_state_t state, state_nxt;
  logic [SAMPLE_W-1:0] lo;
  logic [WORD_W-1:0] word;
  logic wr_pend, at_max, accept, complete, rearm, flush_wr;
  always_comb begin
    at_max = sample_count == MAX_CNT;
    accept = dv && (state == IDLE || (state == CAPTURE && !at_max));
    // an odd count means the low half is already held, so this sample closes a word
    complete = accept && state == CAPTURE && sample_count[0];
    rearm = arm && state == DONE;
    flush_wr = state == FLUSH && !fifo_full;
    state_nxt = state == IDLE    ? (dv ? CAPTURE : IDLE)
              : state == CAPTURE ? ((!dv || at_max) ? (sample_count[0] ? FLUSH : DONE) : CAPTURE)
              : state == FLUSH   ? DONE
              : (arm ? IDLE : DONE);
  end
  always_ff @(posedge dclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lo <= '0;
      word <= '0;
      wr_pend <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din <= '0;
      capture_done <= 1'b0;
      sample_count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_pend <= complete && !fifo_full;
      fifo_wr_en <= wr_pend || flush_wr;
      capture_done <= state == DONE && state_nxt == DONE;
      if (complete) word <= {data, lo};
      if (wr_pend) fifo_din <= word;
      else if (flush_wr) fifo_din <= {{(WORD_W-SAMPLE_W){1'b0}}, lo};
      if (rearm) begin
        sample_count <= '0;
        overflow <= 1'b0;
        lo <= '0;
      end else begin
        if (accept) sample_count <= sample_count + 1'b1;
        if (accept && !sample_count[0]) lo <= data;
        if ((complete || state == FLUSH) && fifo_full) overflow <= 1'b1;
      end
    end
`ifdef CAPTURE_SEQ_CHECK_EN
  capture_seq_check u_seq (
    .dclk    (dclk),
    .rst_n   (rst_n),
    .clear   (rearm),
    .first   (state == IDLE),
    .valid   (accept),
    .data    (data),
    .seq_err (seq_err)
  );
`else
  assign seq_err = 1'b0;
`endif
endmodule

// File: doc/capture_sink.md
# capture_sink

Receive-side endpoint for the ADC capture stream. Consumes the `dv`/`data` sample stream produced by the capture controller and packs pairs of 16-bit samples into 32-bit words. Writes those words into the Xillybus upstream FIFO and reports completion, overflow and (optionally) sequence errors. Sits between the capture controller and the FIFO write port, in the `dclk` domain.

## Interface
- `MAX_SAMPLES`, 16384: samples accepted per capture run before forcing completion.
- `dclk`  in  1  sample clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  single-cycle pulse; re-arms the block from DONE.
- `dv`  in  1  sample valid from the capture controller.
- `data`  in  16  sample value, qualified by `dv`.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write strobe, registered.
- `fifo_din`  out  32  FIFO write data, registered.
- `capture_done`  out  1  high while in DONE.
- `sample_count`  out  15  samples accepted this run (0..MAX_SAMPLES).
- `overflow`  out  1  sticky; a word was dropped because of `fifo_full`.
- `seq_err`  out  1  sticky sequence error; constant 0 when the checker is not compiled in.

## Operation
- States: IDLE, CAPTURE, FLUSH, DONE. Reset → IDLE.
- IDLE:
  - `dv`=1 → accept the sample into the low half; `sample_count`=1; go to CAPTURE.
  - `dv`=0 → stay.
- CAPTURE, for each `dv`=1 cycle:
  - Accept `data`; increment `sample_count`.
  - Even-index samples (0, 2, …) go to `[15:0]`; odd-index samples go to `[31:16]`.
  - Completing the odd half makes a word ready.
- Word ready with `fifo_full`=0 → the word is written. Word ready with `fifo_full`=1 → the word is discarded and `overflow` is set. No retry and no stall; the source cannot be back-pressured.
- Leaving CAPTURE, when `dv`=0 or `sample_count` reaches `MAX_SAMPLES`:
  - Half-word pending → FLUSH.
  - Otherwise → DONE.
- FLUSH: write the pending sample with `[31:16]`=0, subject to the same full/drop rule; go to DONE.
- DONE:
  - `dv` and `data` are ignored.
  - `arm`=1 → clear `sample_count`, `overflow`, `seq_err` and the pending half; go to IDLE.
  - `arm` in any other state is ignored.
- Samples arriving after `MAX_SAMPLES` is reached while `dv` stays high are dropped silently. They do not set `overflow`.
- `sample_count` saturates at `MAX_SAMPLES`; it never wraps.

## Timing
- Reset values: `fifo_wr_en`=0, `fifo_din`=0, `capture_done`=0, `sample_count`=0, `overflow`=0, `seq_err`=0.
- Sample k accepted at edge N. If it completes a word, `fifo_wr_en`=1 with that word for exactly one cycle, asserted after edge N+1.
- `fifo_full` is evaluated at edge N, the same edge that completes the word.
- Back-to-back words (continuous `dv`) give `fifo_wr_en` high every second cycle.
- FLUSH write: `fifo_wr_en` asserted the cycle after FLUSH is entered.
- `capture_done` rises the cycle after the last write strobe, or the cycle after the transition if no write is pending.
- `dv` falling and `MAX_SAMPLES` reached on the same edge is a single completion event.
- `arm` and `dv` on the same edge in DONE: the block goes to IDLE; that `dv` sample is not accepted.
- `rst_n` low mid-run:
  - Immediate clear; any partial word is lost.
  - A `fifo_wr_en` in flight is deasserted asynchronously.

## Configuration
- `CAPTURE_SEQ_CHECK_EN` defined:
  - The first accepted sample of a run loads `expected` = `data`+1, modulo 2^16.
  - Each later accepted sample is compared with `expected`.
  - Mismatch sets `seq_err` sticky, and `expected` resyncs to `data`+1.
  - Wrap 0xFFFF → 0x0000 is legal.
  - Samples dropped beyond `MAX_SAMPLES` are not checked.
- `CAPTURE_SEQ_CHECK_EN` undefined: no checker logic; `seq_err` is tied to 0.

## Structure
- Shared package `capture_pkg`:
  - State enum `cap_state_t` {IDLE, CAPTURE, FLUSH, DONE}.
  - `SAMPLE_W`=16, `WORD_W`=32.
  - Default `MAX_SAMPLES`.
- One sub-module, `capture_seq_check`:
  - Inputs: `dclk`, `rst_n`, `clear`, `first`, `valid`, `data`.
  - Output: `seq_err`.
  - Instantiated only under `CAPTURE_SEQ_CHECK_EN`.
- Packing, FIFO write and FSM live in `capture_sink`.

## Test plan
- Ramp 0..16383, `dv` high 16384 cycles, `fifo_full`=0 → 8192 writes, first `fifo_din`=0x0001_0000, last 0x3FFF_3FFE. `capture_done`=1, `sample_count`=16384, `overflow`=0, `seq_err`=0.
- 5 samples 0x0010..0x0014, then `dv`=0 → writes 0x0011_0010, 0x0013_0012, then FLUSH 0x0000_0014. `capture_done` one cycle after the last strobe.
- `fifo_full`=1 while the 2nd word completes, 6-sample ramp → exactly 2 writes; `overflow`=1 and stays 1 until `arm`.
- With `CAPTURE_SEQ_CHECK_EN`: stream 0xFFFE, 0xFFFF, 0x0000, 0x0005, 0x0006 → `seq_err` rises only after the 0x0005 sample; no error at the wrap. Without the macro: `seq_err`=0.
- `dv` held 20000 cycles with `MAX_SAMPLES`=16384 → exactly 8192 writes, `sample_count`=16384, `overflow`=0. Then `arm` pulse → IDLE, counters cleared, next run captured.
- `rst_n` pulsed low after 3 samples → all outputs 0 immediately, no write of the partial word. A subsequent run starts from IDLE with a new low-half pairing.
